hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle sequencer for the MIPS multiply/divide path and owner of the HI/LO register pair. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the instruction word. Multiply and divide run over 34 cycles with a valid/ready handshake, and any HI/LO access that arrives while an operation is in flight is stalled. It sits beside the single-cycle ALU chip, taking the same `instr`/`in0`/`in1` operands, and replaces the ALU's combinational HI/LOW outputs.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `valid` in 1: `instr`/`in0`/`in1` are valid this cycle.
- `instr` in 32: MIPS instruction word; opcode `[31:26]`, funct `[5:0]`.
- `in0` in 32: rs value; dividend, multiplicand, or MTHI/MTLO source.
- `in1` in 32: rt value; divisor or multiplier.
- `ready` out 1: controller idle; a MULT/DIV start is accepted when `valid && ready`.
- `stall` out 1: a HI/LO instruction is presented while busy; upstream must hold it.
- `out` out 32: MFHI/MFLO read data, combinational.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `done` out 1: one-cycle pulse when HI/LO receive a result.
- `dz` out 1: divide-by-zero flag, valid with `done`.

## Operation
- **Decode.** An instruction is a HI/LO op iff opcode==0 and funct ∈ {0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}. All other instructions are ignored and have no state effect.
- **States.**
  - IDLE → PREP on accepted MULT/DIV. Operands, op type and signs are latched.
  - PREP: takes absolute values for the signed ops and clears the accumulator. 1 cycle. → ITER, count=0.
  - ITER: 32 iterations, count 0..31.
    - Multiply: shift-add, 64-bit accumulator.
    - Divide: restoring division with a 33-bit partial remainder.
    - At count==31 → FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`. → IDLE.
- **Results.**
  - Multiply: {HI,LO} = 64-bit product. Signed product is negated in two's complement iff the operand signs differ.
  - Divide: LO = quotient, HI = remainder. Signed quotient is negated iff the signs differ; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Divide by zero (`in1`==0): HI=`in0` unchanged, LO=0xFFFFFFFF, `dz`=1 in the `done` cycle. The full 34-cycle latency still applies.
- **MTHI/MTLO.** When `valid` and IDLE, the register is written from `in0` at the next edge. No busy period, no `done` pulse.
- **MFHI/MFLO.**
  - `out` = current HI or LO when `valid` and decoded; `out` = 0 otherwise.
  - When IDLE the read is valid the same cycle.
- **Stall.** `stall` = `valid` && decoded HI/LO op && state≠IDLE. This includes a MULT/DIV presented while busy.
- `ready` = (state==IDLE), independent of `valid`.

## Timing
- **Reset values:** state=IDLE, `hi`=0, `lo`=0, `done`=0, `dz`=0, count=0. `ready`=1 and `stall`=0 follow from IDLE.
- **Latency.** Accept edge at T0. `ready`=0 in cycles T0+1..T0+34. At T0+34 (FIX) `done`=1; `hi`/`lo` are updated at the edge ending FIX. `ready`=1 from T0+35.
- **Back-to-back.** A new MULT/DIV may be accepted in the first cycle after FIX. MFHI in that same cycle returns the new result.
- **Simultaneous events.** In FIX, a stalled MFHI sees the old HI with `stall`=1. The next cycle it sees the new HI with `stall`=0.
- **Reset mid-operation.** Any state returns to IDLE immediately. HI/LO are zeroed and the in-flight operation is discarded.
- While busy, `in0`/`in1` changes have no effect; operands are latched only at acceptance.

## Test plan
- **Unsigned-small MULT.** MULT (instr 0x00430018), `in0`=0x00004001, `in1`=3 → `done` 34 cycles after acceptance; `hi`=0, `lo`=0x0000C003.
- **Sign handling.**
  - MULT −1×2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- **Signed divide.**
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero.** DIVU 7/0 → `hi`=7, `lo`=0xFFFFFFFF, `dz`=1 with `done`; `dz`=0 on a subsequent normal DIVU 9/3 (`lo`=3, `hi`=0).
- **Stall and hold.** MFHI presented at T0+5 of a MULT → `stall`=1 through T0+34, 0 at T0+35 with `out`=new HI. A second MULT presented while busy is not accepted until `ready`=1.
- **Direct writes and reset.**
  - MTLO `in0`=0xDEADBEEF, then MFLO → `out`=0xDEADBEEF next cycle, `done` stays 0.
  - Assert `reset` at T0+10 of a DIV → `ready`=1 and `hi`=`lo`=0 immediately, no `done` pulse.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// Issue-side bundle of the HI/LO multiply/divide controller: instruction and operands in,
// handshake, HI/LO state and MFHI/MFLO read data out.
interface hilo_muldiv_ctrl_if;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        ready;
    logic        stall;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        dz;

    modport master (
        output valid, instr, in0, in1,
        input  ready, stall, out, hi, lo, done, dz
    );

    modport slave (
        input  valid, instr, in0, in1,
        output ready, stall, out, hi, lo, done, dz
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// MIPS HI/LO owner: decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and sequences a 34-cycle
// shift-add multiply or restoring divide (IDLE -> PREP -> 32x ITER -> FIX).
module hilo_muldiv_ctrl (
    input  logic              clk,
    input  logic              reset,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [5:0]  funct;
    logic        rtype;
    logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_muldiv, is_hilo;

    assign funct     = bus.instr[5:0];
    assign rtype     = (bus.instr[31:26] == 6'd0);
    assign is_mfhi   = rtype && (funct == FN_MFHI);
    assign is_mflo   = rtype && (funct == FN_MFLO);
    assign is_mthi   = rtype && (funct == FN_MTHI);
    assign is_mtlo   = rtype && (funct == FN_MTLO);
    assign is_muldiv = rtype && ((funct == FN_MULT) || (funct == FN_MULTU) ||
                                 (funct == FN_DIV)  || (funct == FN_DIVU));
    assign is_hilo   = is_mfhi || is_mflo || is_mthi || is_mtlo || is_muldiv;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[25:6], rem_q[32]};

    // Iteration datapath: multiplicand/divisor sit in op_a_q/op_b_q as magnitudes after PREP.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_by_zero;
    logic        signs_differ;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] dz_hi;

    assign mul_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_a_q} : 33'd0);
    assign div_shift    = {rem_q[31:0], acc_q[31]};
    assign div_diff     = {1'b0, div_shift} - {2'b00, op_b_q};
    assign div_by_zero  = is_div_q && (op_b_q == 32'd0);
    assign signs_differ = neg_a_q ^ neg_b_q;
    assign prod_fixed   = signs_differ ? -acc_q : acc_q;
    assign quo_fixed    = signs_differ ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fixed    = neg_a_q ? -rem_q[31:0] : rem_q[31:0];
    // Re-negating the magnitude recovers the original dividend, including 0x80000000.
    assign dz_hi        = neg_a_q ? -op_a_q : op_a_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch below can leave a latch behind.
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.valid && is_muldiv) begin
                    state_d  = S_PREP;
                    is_div_d = funct[1];
                    neg_a_d  = ~funct[0] & bus.in0[31];
                    neg_b_d  = ~funct[0] & bus.in1[31];
                    op_a_d   = bus.in0;
                    op_b_d   = bus.in1;
                end else if (bus.valid && is_mthi) begin
                    hi_d = bus.in0;
                end else if (bus.valid && is_mtlo) begin
                    lo_d = bus.in0;
                end
            end

            S_PREP: begin
                op_a_d  = neg_a_q ? -op_a_q : op_a_q;
                op_b_d  = neg_b_q ? -op_b_q : op_b_q;
                acc_d   = {32'd0, (is_div_q ? op_a_d : op_b_d)};
                rem_d   = '0;
                count_d = '0;
                state_d = S_ITER;
            end

            S_ITER: begin
                if (is_div_q) begin
                    if (!div_diff[33]) begin
                        rem_d = div_diff[32:0];
                        acc_d = {32'd0, acc_q[30:0], 1'b1};
                    end else begin
                        rem_d = div_shift;
                        acc_d = {32'd0, acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (div_by_zero) begin
                    hi_d = dz_hi;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end else begin
                    hi_d = prod_fixed[63:32];
                    lo_d = prod_fixed[31:0];
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge _d values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.stall = bus.valid && is_hilo && (state_q != S_IDLE);
    assign bus.done  = (state_q == S_FIX);
    assign bus.dz    = (state_q == S_FIX) && div_by_zero;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.out   = (bus.valid && is_mfhi) ? hi_q :
                       (bus.valid && is_mflo) ? lo_q : 32'd0;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for stall, back-to-back, MTHI/MTLO and reset.
module tb_hilo_muldiv_ctrl;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    endtask

    function automatic logic [31:0] mk_instr(input logic [5:0] fn);
        return {6'd0, 5'd2, 5'd3, 10'd0, fn};
    endfunction

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero like MIPS.
    function automatic void model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] m_hi, output logic [31:0] m_lo,
                                  output logic m_dz);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] u;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        m_dz = 1'b0;
        m_hi = '0;
        m_lo = '0;
        if (fn == FN_MULT) begin
            p = sa * sb;
            {m_hi, m_lo} = p;
        end else if (fn == FN_MULTU) begin
            u = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = u;
        end else if (b == 32'd0) begin
            m_hi = a;
            m_lo = '1;
            m_dz = 1'b1;
        end else if (fn == FN_DIV) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
    endfunction

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #1;
        bus.valid = 1'b1;
        bus.instr = mk_instr(fn);
        bus.in0   = a;
        bus.in1   = b;
    endtask

    // Called right after issue(); cycle k is T0+k relative to the accepting edge.
    task automatic wait_result(output int done_at, output int back_at, output int n_done,
                               output logic r_dz, output logic [31:0] r_hi, output logic [31:0] r_lo);
        done_at = -1;
        back_at = -1;
        n_done  = 0;
        r_dz    = 1'b0;
        r_hi    = '0;
        r_lo    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin
                bus.valid = 1'b0;
                bus.in0   = $urandom;
                bus.in1   = $urandom;
            end
            #1;
            if (bus.done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    r_dz    = bus.dz;
                end
            end
            if (bus.ready) begin
                back_at = k;
                r_hi    = bus.hi;
                r_lo    = bus.lo;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dz);
        int done_at, back_at, n_done;
        logic r_dz;
        logic [31:0] r_hi, r_lo;
        issue(fn, a, b);
        #1 check({tag, "_ready_at_issue"}, 32'(bus.ready), 32'd1);
        wait_result(done_at, back_at, n_done, r_dz, r_hi, r_lo);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd34);
        check({tag, "_ready_cycle"}, 32'(back_at), 32'd35);
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_dz"}, 32'(r_dz), 32'(e_dz));
        check({tag, "_hi"}, r_hi, e_hi);
        check({tag, "_lo"}, r_lo, e_lo);
        cur_hi = e_hi;
        cur_lo = e_lo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        logic [5:0]  fn;
        logic [31:0] a, b, e_hi, e_lo, a2, b2, b_hi, b_lo, old_hi;
        logic        e_dz, b_dz;
        int          stall_cnt, rdy_cnt, done_at, back_at, n_done;
        logic        r_dz;
        logic [31:0] r_hi, r_lo;

        vecs[0]  = '{FN_MULT,  32'h0000_4001, 32'd3,        32'h0000_0000, 32'h0000_C003, 1'b0};
        vecs[1]  = '{FN_MULT,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{FN_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{FN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{FN_DIVU,  32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{FN_DIVU,  32'd9,        32'd3,        32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[7]  = '{FN_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[9]  = '{FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{FN_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{FN_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};

        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.instr = '0;
        bus.in0   = '0;
        bus.in1   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_dz",    32'(bus.dz),    32'd0);
        check("rst_hi",    bus.hi,         32'd0);
        check("rst_lo",    bus.lo,         32'd0);
        check("rst_out",   bus.out,        32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        for (int i = 0; i < 24; i++) begin
            fn = FN_MULT + 6'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(fn, a, b, e_hi, e_lo, e_dz);
            run_op($sformatf("rnd%0d", i), fn, a, b, e_hi, e_lo, e_dz);
        end

        // MFHI arriving at T0+5 is held through FIX, then reads the new HI at T0+35.
        a = 32'h1234_5678;
        b = 32'hFFFF_FFF0;
        model(FN_MULT, a, b, e_hi, e_lo, e_dz);
        old_hi = cur_hi;
        issue(FN_MULT, a, b);
        stall_cnt = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk); #1;
            if (k == 1) bus.valid = 1'b0;
            if (k == 5) begin
                bus.valid = 1'b1;
                bus.instr = mk_instr(FN_MFHI);
            end
            #1;
            if (bus.stall) stall_cnt++;
            if (k == 34) begin
                check("fix_done", 32'(bus.done), 32'd1);
                check("fix_out_old_hi", bus.out, old_hi);
            end
        end
        check("mfhi_stall_cycles", 32'(stall_cnt), 32'd30);
        @(negedge clk); #2;
        check("t35_stall", 32'(bus.stall), 32'd0);
        check("t35_ready", 32'(bus.ready), 32'd1);
        check("t35_out_new_hi", bus.out, e_hi);
        bus.valid = 1'b0;
        cur_hi = e_hi;
        cur_lo = e_lo;

        // Second MULT held while busy, accepted back-to-back in the first cycle after FIX.
        a  = 32'h0000_BEEF;
        b  = 32'h0001_0001;
        a2 = 32'hFFFF_8000;
        b2 = 32'h0000_0123;
        model(FN_MULTU, a, b, e_hi, e_lo, e_dz);
        model(FN_MULT, a2, b2, b_hi, b_lo, b_dz);
        issue(FN_MULTU, a, b);
        stall_cnt = 0;
        rdy_cnt   = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk); #1;
            if (k == 1) bus.valid = 1'b0;
            if (k == 3) begin
                bus.valid = 1'b1;
                bus.instr = mk_instr(FN_MULT);
                bus.in0   = a2;
                bus.in1   = b2;
            end
            #1;
            if (bus.stall) stall_cnt++;
            if (bus.ready) rdy_cnt++;
        end
        check("held_stall_cycles", 32'(stall_cnt), 32'd32);
        check("held_ready_cycles", 32'(rdy_cnt), 32'd0);
        @(negedge clk); #2;
        check("b2b_ready", 32'(bus.ready), 32'd1);
        check("b2b_stall", 32'(bus.stall), 32'd0);
        check("b2b_first_hi", bus.hi, e_hi);
        check("b2b_first_lo", bus.lo, e_lo);
        wait_result(done_at, back_at, n_done, r_dz, r_hi, r_lo);
        check("b2b_done_cycle", 32'(done_at), 32'd34);
        check("b2b_ready_cycle", 32'(back_at), 32'd35);
        check("b2b_second_hi", r_hi, b_hi);
        check("b2b_second_lo", r_lo, b_lo);
        cur_hi = b_hi;
        cur_lo = b_lo;

        // MTLO / MTHI write at the next edge, with no busy period and no done pulse.
        @(negedge clk); #1;
        bus.valid = 1'b1;
        bus.instr = mk_instr(FN_MTLO);
        bus.in0   = 32'hDEAD_BEEF;
        #1 check("mtlo_out", bus.out, 32'd0);
        @(negedge clk); #1;
        bus.instr = mk_instr(FN_MFLO);
        bus.in0   = 32'd0;
        #1;
        check("mflo_out", bus.out, 32'hDEAD_BEEF);
        check("mtlo_done", 32'(bus.done), 32'd0);
        check("mtlo_ready", 32'(bus.ready), 32'd1);
        check("mtlo_hi_kept", bus.hi, cur_hi);
        @(negedge clk); #1;
        bus.instr = mk_instr(FN_MTHI);
        bus.in0   = 32'h0BAD_F00D;
        @(negedge clk); #1;
        bus.instr = mk_instr(FN_MFHI);
        #1 check("mfhi_out", bus.out, 32'h0BAD_F00D);
        bus.valid = 1'b0;
        #1 check("mfhi_no_valid_out", bus.out, 32'd0);
        cur_hi = 32'h0BAD_F00D;
        cur_lo = 32'hDEAD_BEEF;

        // Non-HI/LO encodings and MULT without valid have no effect.
        @(negedge clk); #1;
        bus.valid = 1'b1;
        bus.instr = {6'h08, 20'h0, FN_MULT};
        bus.in0   = $urandom;
        bus.in1   = $urandom;
        #1 check("ign_opcode_stall", 32'(bus.stall), 32'd0);
        @(negedge clk); #1;
        bus.instr = {6'h00, 20'h0, 6'h20};
        @(negedge clk); #1;
        bus.instr = {6'h09, 20'h0, FN_MTHI};
        @(negedge clk); #1;
        bus.instr = {6'h0F, 20'h0, FN_MFHI};
        #1 check("ign_mfhi_out", bus.out, 32'd0);
        @(negedge clk); #1;
        bus.valid = 1'b0;
        bus.instr = mk_instr(FN_MULT);
        @(negedge clk); #2;
        check("ign_ready", 32'(bus.ready), 32'd1);
        check("ign_hi", bus.hi, cur_hi);
        check("ign_lo", bus.lo, cur_lo);

        // Reset at T0+10 of a DIV: immediate idle, HI/LO cleared, no done afterwards.
        issue(FN_DIV, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (k == 1) bus.valid = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        n_done  = 0;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.done) n_done++;
            if (bus.ready) rdy_cnt++;
        end
        check("postrst_done_count", 32'(n_done), 32'd0);
        check("postrst_ready_cycles", 32'(rdy_cnt), 32'd40);
        check("postrst_hi", bus.hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
